// File: rtl/player_move_ctrl_if.sv
// Handshake bundle between the move controller and the wall-collision checker.
// The controller drives the candidate move; the checker answers with done/valid.
interface player_move_ctrl_if;
   logic       lim_rst_n;
   logic       lim_start;
   logic [9:0] lim_x;
   logic [9:0] lim_y;
   logic [1:0] lim_l_r;
   logic [1:0] lim_u_d;
   logic       lim_done;
   logic       lim_valid;

   modport master (
      output lim_rst_n, lim_start, lim_x, lim_y, lim_l_r, lim_u_d,
      input  lim_done, lim_valid
   );

   modport slave (
      input  lim_rst_n, lim_start, lim_x, lim_y, lim_l_r, lim_u_d,
      output lim_done, lim_valid
   );
endinterface

// File: rtl/player_move_ctrl.sv
// Per-frame player movement sequencer: tries an X step, then a Y step, through the
// wall-collision checker and commits each accepted step to the position registers.
module player_move_ctrl #(
   parameter logic [9:0] X_INIT  = 10'd140,
   parameter logic [9:0] Y_INIT  = 10'd60,
   parameter logic [9:0] STEP    = 10'd1,
   parameter logic [9:0] X_MIN   = 10'd80,
   parameter logic [9:0] X_MAX   = 10'd549,
   parameter logic [9:0] Y_MAX   = 10'd469,
   parameter logic [3:0] TIMEOUT = 4'd15
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_tick,
   input  logic                  i_btn_l,
   input  logic                  i_btn_r,
   input  logic                  i_btn_u,
   input  logic                  i_btn_d,
   player_move_ctrl_if.master    lim,
   output logic [9:0]            o_player_x,
   output logic [9:0]            o_player_y,
   output logic                  o_busy,
   output logic                  o_moved,
   output logic [7:0]            o_overrun_cnt
);

   typedef enum logic [2:0] {
      S_IDLE, S_CLR_X, S_GO_X, S_WAIT_X, S_CLR_Y, S_GO_Y, S_WAIT_Y, S_FIN
   } state_t;

   localparam logic [1:0] DIR_NONE = 2'd0;
   localparam logic [1:0] DIR_POS  = 2'd1;
   localparam logic [1:0] DIR_NEG  = 2'd2;

   state_t     r_state;
   logic [9:0] r_px, r_py;
   logic [1:0] r_dx, r_dy;
   logic [3:0] r_tmo;
   logic       r_busy, r_moved;
   logic [7:0] r_ovr;
   logic       r_lim_rst_n, r_lim_start;
   logic [9:0] r_lim_x, r_lim_y;
   logic [1:0] r_lim_l_r, r_lim_u_d;

   logic [1:0]  w_dx, w_dy;
   logic [10:0] w_cx_new, w_cy_idle, w_cx, w_cy;
   logic        w_ok_x, w_ok_y, w_x_commit, w_y_commit, w_tmo, w_resolve;
   logic [9:0]  w_px_next;

   // 11-bit result so both underflow and overflow show up in bit 10
   function automatic logic [10:0] f_step(input logic [9:0] pos, input logic [1:0] dir);
      if (dir == DIR_NEG) f_step = {1'b0, pos} - {1'b0, STEP};
      else                f_step = {1'b0, pos} + {1'b0, STEP};
   endfunction

   assign w_dx = (i_btn_r & ~i_btn_l) ? DIR_POS : (i_btn_l & ~i_btn_r) ? DIR_NEG : DIR_NONE;
   assign w_dy = (i_btn_d & ~i_btn_u) ? DIR_POS : (i_btn_u & ~i_btn_d) ? DIR_NEG : DIR_NONE;

   assign w_cx_new  = f_step(r_px, w_dx);
   assign w_cy_idle = f_step(r_py, w_dy);
   assign w_cx      = f_step(r_px, r_dx);
   assign w_cy      = f_step(r_py, r_dy);

   assign w_ok_x = ~w_cx[10] & (w_cx[9:0] >= X_MIN) & (w_cx[9:0] <= X_MAX);
   assign w_ok_y = ~w_cy[10] & (w_cy[9:0] <= Y_MAX);

   assign w_tmo      = (r_tmo == TIMEOUT - 4'd1);
   assign w_resolve  = lim.lim_done | w_tmo;
   assign w_x_commit = (r_state == S_WAIT_X) & lim.lim_done & lim.lim_valid & w_ok_x;
   assign w_y_commit = (r_state == S_WAIT_Y) & lim.lim_done & lim.lim_valid & w_ok_y;
   // The Y candidate must see an X commit made on the same edge
   assign w_px_next  = w_x_commit ? w_cx[9:0] : r_px;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_px        <= X_INIT;
         r_py        <= Y_INIT;
         r_dx        <= DIR_NONE;
         r_dy        <= DIR_NONE;
         r_tmo       <= '0;
         r_busy      <= 1'b0;
         r_moved     <= 1'b0;
         r_ovr       <= '0;
         r_lim_rst_n <= 1'b0;
         r_lim_start <= 1'b0;
         r_lim_x     <= '0;
         r_lim_y     <= '0;
         r_lim_l_r   <= DIR_NONE;
         r_lim_u_d   <= DIR_NONE;
      end else begin
         r_moved <= 1'b0;
         if (i_tick && r_busy && (r_ovr != 8'hFF))
            r_ovr <= r_ovr + 8'd1;

         case (r_state)
            S_IDLE: begin
               r_lim_rst_n <= 1'b0;
               if (i_tick && ((w_dx != DIR_NONE) || (w_dy != DIR_NONE))) begin
                  r_dx   <= w_dx;
                  r_dy   <= w_dy;
                  r_busy <= 1'b1;
                  if (w_dx != DIR_NONE) begin
                     r_lim_x   <= w_cx_new[9:0];
                     r_lim_y   <= r_py;
                     r_lim_l_r <= w_dx;
                     r_lim_u_d <= DIR_NONE;
                     r_state   <= S_CLR_X;
                  end else begin
                     r_lim_x   <= r_px;
                     r_lim_y   <= w_cy_idle[9:0];
                     r_lim_l_r <= DIR_NONE;
                     r_lim_u_d <= w_dy;
                     r_state   <= S_CLR_Y;
                  end
               end
            end

            S_CLR_X, S_CLR_Y: begin
               r_lim_rst_n <= 1'b1;
               r_lim_start <= 1'b1;
               r_state     <= (r_state == S_CLR_X) ? S_GO_X : S_GO_Y;
            end

            S_GO_X, S_GO_Y: begin
               r_lim_start <= 1'b0;
               r_tmo       <= '0;
               r_state     <= (r_state == S_GO_X) ? S_WAIT_X : S_WAIT_Y;
            end

            S_WAIT_X: begin
               r_tmo <= r_tmo + 4'd1;
               if (w_resolve) begin
                  r_lim_rst_n <= 1'b0;
                  if (w_x_commit) begin
                     r_px    <= w_cx[9:0];
                     r_moved <= 1'b1;
                  end
                  if (r_dy != DIR_NONE) begin
                     r_lim_x   <= w_px_next;
                     r_lim_y   <= w_cy[9:0];
                     r_lim_l_r <= DIR_NONE;
                     r_lim_u_d <= r_dy;
                     r_state   <= S_CLR_Y;
                  end else begin
                     r_state <= S_FIN;
                  end
               end
            end

            S_WAIT_Y: begin
               r_tmo <= r_tmo + 4'd1;
               if (w_resolve) begin
                  r_lim_rst_n <= 1'b0;
                  if (w_y_commit) begin
                     r_py    <= w_cy[9:0];
                     r_moved <= 1'b1;
                  end
                  r_state <= S_FIN;
               end
            end

            S_FIN: begin
               r_lim_rst_n <= 1'b0;
               r_busy      <= 1'b0;
               r_state     <= S_IDLE;
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign lim.lim_rst_n = r_lim_rst_n;
   assign lim.lim_start = r_lim_start;
   assign lim.lim_x     = r_lim_x;
   assign lim.lim_y     = r_lim_y;
   assign lim.lim_l_r   = r_lim_l_r;
   assign lim.lim_u_d   = r_lim_u_d;

   assign o_player_x    = r_px;
   assign o_player_y    = r_py;
   assign o_busy        = r_busy;
   assign o_moved       = r_moved;
   assign o_overrun_cnt = r_ovr;

endmodule

// File: tb/tb_player_move_ctrl.sv
// Bench for player_move_ctrl: plays the collision checker and predicts each move
// from the movement rules (position, bounds, checker answer, timeout).
`timescale 1ns/1ps
module tb_player_move_ctrl;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick = 1'b0;
   logic       bl = 1'b0, br = 1'b0, bu = 1'b0, bd = 1'b0;
   logic [9:0] px, py;
   logic       busy, moved;
   logic [7:0] ovr;

   player_move_ctrl_if lif();

   player_move_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .i_tick        (tick),
      .i_btn_l       (bl),
      .i_btn_r       (br),
      .i_btn_u       (bu),
      .i_btn_d       (bd),
      .lim           (lif.master),
      .o_player_x    (px),
      .o_player_y    (py),
      .o_busy        (busy),
      .o_moved       (moved),
      .o_overrun_cnt (ovr)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int mx    = 140;
   int my    = 60;
   int movr  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // One tick: d*/v* are the checker's answer delay (cycles after start) and valid bit per axis
   task automatic run_move(input logic l, r, u, d, input int d0, input bit v0,
                           input int d1, input bit v1, input bit ovr_t, input bit rst_y);
      int dxs, dys, cand;
      int dly[2];
      bit vld[2];
      int elx[2], ely[2], edl[2], edu[2];
      int nax = 0, cyc = 0, mv_exp = 0;
      int ax = 0, since = 0, busyc = 0, mv = 0;
      bit armed = 0, fin = 0, aborted = 0;

      dxs = (r && !l) ? 1 : (l && !r) ? -1 : 0;
      dys = (d && !u) ? 1 : (u && !d) ? -1 : 0;
      if (dxs != 0) begin
         cand = mx + dxs;
         dly[nax] = d0; vld[nax] = v0;
         elx[nax] = cand & 1023; ely[nax] = my;
         edl[nax] = (dxs > 0) ? 1 : 2; edu[nax] = 0;
         if (d0 <= 15 && v0 && cand >= 80 && cand <= 549) begin mx = cand; mv_exp++; end
         cyc += 2 + ((d0 < 15) ? d0 : 15);
         nax++;
      end
      if (dys != 0) begin
         cand = my + dys;
         dly[nax] = d1; vld[nax] = v1;
         elx[nax] = mx; ely[nax] = cand & 1023;
         edl[nax] = 0; edu[nax] = (dys > 0) ? 1 : 2;
         if (d1 <= 15 && v1 && cand >= 0 && cand <= 469) begin my = cand; mv_exp++; end
         cyc += 2 + ((d1 < 15) ? d1 : 15);
         nax++;
      end
      if (nax > 0) cyc++;

      bl = l; br = r; bu = u; bd = d;
      tick = 1'b1;
      step();
      tick = 1'b0;

      for (int c = 0; c < 100 && !fin; c++) begin
         if (moved === 1'b1) mv++;
         if (busy !== 1'b1) begin
            fin = 1;
         end else begin
            busyc++;
            if (lif.lim_start === 1'b1) begin
               if (ax < nax) begin
                  chk("start_rst_n", lif.lim_rst_n, 1);
                  chk("lim_x", lif.lim_x, elx[ax]);
                  chk("lim_y", lif.lim_y, ely[ax]);
                  chk("lim_l_r", lif.lim_l_r, edl[ax]);
                  chk("lim_u_d", lif.lim_u_d, edu[ax]);
               end else begin
                  chk("extra_start", ax, nax - 1);
               end
               armed = 1; since = 0; ax++;
            end else if (armed) begin
               since++;
            end
            lif.lim_done = 1'b0; lif.lim_valid = 1'b0; tick = 1'b0;
            if (armed && since > 0 && ax <= 2 && since == dly[ax-1]) begin
               lif.lim_done = 1'b1; lif.lim_valid = vld[ax-1]; armed = 0;
            end else if (!armed && $urandom_range(0, 7) == 0) begin
               lif.lim_done = 1'b1; lif.lim_valid = 1'b1;
            end
            if (ovr_t && ax == 1 && armed && since == 1) begin
               tick = 1'b1;
               movr = (movr < 255) ? movr + 1 : 255;
            end
            if (rst_y && ax == 2 && since == 2) begin
               rst = 1'b1;
               #1;
               chk("rst_px", px, 140);
               chk("rst_py", py, 60);
               chk("rst_lim_rst_n", lif.lim_rst_n, 0);
               chk("rst_busy", busy, 0);
               chk("rst_lim_x", lif.lim_x, 0);
               chk("rst_ovr", ovr, 0);
               lif.lim_done = 1'b0; lif.lim_valid = 1'b0; tick = 1'b0;
               @(negedge clk) rst = 1'b0;
               mx = 140; my = 60; movr = 0;
               aborted = 1; fin = 1;
            end
            if (!aborted) step();
         end
      end
      lif.lim_done = 1'b0; lif.lim_valid = 1'b0; tick = 1'b0;
      if (aborted) return;
      if (!fin) chk("move_end", busy, 0);
      chk("busy_cycles", busyc, cyc);
      chk("moved_cnt", mv, mv_exp);
      chk("player_x", px, mx);
      chk("player_y", py, my);
      chk("axes", ax, nax);
      chk("overrun", ovr, movr);
      chk("idle_rst_n", lif.lim_rst_n, 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      lif.lim_done = 1'b0;
      lif.lim_valid = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_px", px, 140);
      chk("reset_py", py, 60);
      chk("reset_rst_n", lif.lim_rst_n, 0);
      chk("reset_start", lif.lim_start, 0);
      chk("reset_lim_x", lif.lim_x, 0);
      chk("reset_lim_y", lif.lim_y, 0);
      chk("reset_l_r", lif.lim_l_r, 0);
      chk("reset_u_d", lif.lim_u_d, 0);
      chk("reset_busy", busy, 0);
      chk("reset_moved", moved, 0);
      chk("reset_ovr", ovr, 0);
      @(negedge clk) rst = 1'b0;

      run_move(0, 1, 0, 0, 3, 1, 0, 0, 0, 0);      // right, accepted
      run_move(1, 0, 1, 0, 3, 1, 3, 1, 0, 0);      // left then up
      run_move(0, 0, 0, 1, 0, 0, 2, 0, 0, 0);      // down, checker says invalid
      run_move(0, 1, 0, 0, 20, 1, 0, 0, 0, 0);     // no lim_done: timeout
      run_move(0, 1, 0, 0, 15, 1, 0, 0, 0, 0);     // done on last allowed cycle
      run_move(0, 0, 0, 0, 1, 1, 1, 1, 0, 0);      // no direction
      run_move(1, 1, 1, 1, 1, 1, 1, 1, 0, 0);      // opposing buttons cancel
      run_move(0, 1, 0, 1, 4, 1, 4, 1, 1, 0);      // overrun tick mid-move

      for (int i = 0; i < 70; i++)
         run_move(1, 0, 0, 0, $urandom_range(1, 3), 1, 0, 0, 0, 0);
      for (int i = 0; i < 70; i++)
         run_move(0, 0, 1, 0, 0, 0, $urandom_range(1, 3), 1, 0, 0);
      for (int i = 0; i < 480; i++)
         run_move(0, 1, 0, 1, $urandom_range(1, 3), 1, $urandom_range(1, 3), 1, 0, 0);

      for (int i = 0; i < 300; i++)
         run_move($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom_range(1, 18), $urandom_range(0, 3) != 0,
                  $urandom_range(1, 18), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 7) == 0, 0);

      run_move(1, 0, 1, 0, 2, 1, 5, 1, 0, 1);      // reset during Y wait
      run_move(0, 1, 0, 0, 2, 1, 0, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
